cache_refill_ctrl: RTL and testbench

Miss-handling controller sitting directly downstream of the cache tag stage. It consumes `miss`, `write_back`, `axi_raddr` and `axi_waddr`; evicts the dirty victim line with an 8-beat AXI write burst, then fetches the new line with an 8-beat AXI read burst. Each returned word is written into the cache data array, and a one-cycle `refresh` is issued so the tag stage installs the new tag. The pipeline stays stalled by the tag stage's `miss` until that install completes.

---
 rtl/cache_refill_ctrl_pkg.sv | 34 +++
 rtl/cache_refill_ctrl_beat_counter.sv | 27 ++
 rtl/cache_refill_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// cache_refill_ctrl_pkg: shared geometry, FSM encodings and AXI constants
// for the cache miss-handling (refill) controller.
package cache_refill_ctrl_pkg;

    // Cache geometry: 32-bit address = tag | index | 5-bit byte offset
    localparam int TAG_WIDTH    = 20;
    localparam int INDEX_WIDTH  = 7;
    localparam int LINE_WORDS   = 8;
    localparam int OFFSET_WIDTH = 5;
    localparam int BEAT_WIDTH   = 3;

    // AXI burst shape for one line: 8 beats of 4 bytes, incrementing
    localparam logic [7:0] AXI_LEN        = 8'(LINE_WORDS - 1);
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_WSTRB_FULL = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_AW      = 3'd1,
        S_W       = 3'd2,
        S_B       = 3'd3,
        S_AR      = 3'd4,
        S_R       = 3'd5,
        S_REFRESH = 3'd6
    } state_t;

    // Force an address onto a line boundary (tag stage already aligns,
    // this just keeps stray offset bits off the bus)
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_beat_counter.sv
// axi_beat_counter: 3-bit beat index shared by the W (evict) and R (refill)
// phases. Wraps 7->0, which only happens at the end of a burst.
module axi_beat_counter
    import cache_refill_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  inc,
    output logic [BEAT_WIDTH-1:0] idx,
    output logic                  last
);

    // Beat index: clear at burst start, step on every accepted beat
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == BEAT_WIDTH'(LINE_WORDS - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss handler below the tag stage. Optionally writes the
// dirty victim out (AW/W/B), then refills the line (AR/R) into the data
// array and pulses refresh so the tag stage installs the new tag.
// Optional feature macro: CACHE_WRITEBACK_EN (victim write-back path).
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        miss,
    input  logic        write_back,
    input  logic [31:0] axi_raddr,
    input  logic [31:0] axi_waddr,
    output logic        refresh,
    output logic        refill_we,
    output logic [2:0]  refill_idx,
    output logic [31:0] refill_wdata,
    input  logic [31:0] evict_rdata,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state;
    logic [31:0] araddr_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        refresh_q;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_last;
    logic [2:0]  cnt;

`ifdef CACHE_WRITEBACK_EN
    logic [31:0] awaddr_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
`endif

    axi_beat_counter u_beat_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .idx    (cnt),
        .last   (cnt_last)
    );

    // Refill FSM; all handshake valids/readies and refresh are registered
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            refresh_q <= 1'b0;
`ifdef CACHE_WRITEBACK_EN
            awaddr_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss) begin
                        araddr_q <= line_align(axi_raddr);
`ifdef CACHE_WRITEBACK_EN
                        if (write_back) begin
                            awaddr_q  <= line_align(axi_waddr);
                            awvalid_q <= 1'b1;
                            state     <= S_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= S_AR;
                        end
`else
                        arvalid_q <= 1'b1;
                        state     <= S_AR;
`endif
                    end
                end
`ifdef CACHE_WRITEBACK_EN
                S_AW: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state     <= S_W;
                    end
                end
                S_W: begin
                    if (wready && cnt_last) begin
                        wvalid_q <= 1'b0;
                        bready_q <= 1'b1;
                        state    <= S_B;
                    end
                end
                S_B: begin
                    // Write response code is not inspected
                    if (bvalid) begin
                        bready_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                        state     <= S_AR;
                    end
                end
`endif
                S_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    // Only rlast ends the burst; the counter may wrap first
                    if (rvalid && rlast) begin
                        rready_q  <= 1'b0;
                        refresh_q <= 1'b1;
                        state     <= S_REFRESH;
                    end
                end
                S_REFRESH: begin
                    refresh_q <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign araddr       = araddr_q;
    assign arlen        = AXI_LEN;
    assign arsize       = AXI_SIZE_4B;
    assign arburst      = AXI_BURST_INCR;
    assign arvalid      = arvalid_q;
    assign rready       = rready_q;
    assign refresh      = refresh_q;
    assign refill_idx   = cnt;
    assign refill_we    = rready_q & rvalid;
    assign refill_wdata = rready_q ? rdata : '0;

`ifdef CACHE_WRITEBACK_EN
    assign cnt_clr = (awvalid_q & awready) | (arvalid_q & arready);
    assign cnt_inc = (wvalid_q & wready) | (rready_q & rvalid);

    assign awaddr  = awaddr_q;
    assign awlen   = AXI_LEN;
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign awvalid = awvalid_q;
    // Victim word comes straight from the data array at refill_idx
    assign wdata   = wvalid_q ? evict_rdata : '0;
    assign wstrb   = AXI_WSTRB_FULL;
    assign wlast   = wvalid_q & cnt_last;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
`else
    assign cnt_clr = arvalid_q & arready;
    assign cnt_inc = rready_q & rvalid;

    assign awaddr  = '0;
    assign awlen   = '0;
    assign awsize  = '0;
    assign awburst = '0;
    assign awvalid = 1'b0;
    assign wdata   = '0;
    assign wstrb   = '0;
    assign wlast   = 1'b0;
    assign wvalid  = 1'b0;
    assign bready  = 1'b0;

    // Write-side inputs have no consumer in a read-only cache
    logic unused_wb_inputs;
    assign unused_wb_inputs = ^{write_back, axi_waddr, awready, wready,
                                bvalid, evict_rdata, cnt_last};
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed scoreboard bench for cache_refill_ctrl.
// Stimulus pushes expected AXI/refill traffic into queues; a negedge
// monitor pops and compares as the DUT presents it. Follows the
// CACHE_WRITEBACK_EN build of the design.
module tb_cache_refill_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        miss = 1'b0;
    logic        write_back = 1'b0;
    logic [31:0] axi_raddr = '0;
    logic [31:0] axi_waddr = '0;
    logic        refresh, refill_we;
    logic [2:0]  refill_idx;
    logic [31:0] refill_wdata, evict_rdata;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid;
    logic        wready = 1'b0;
    logic        bvalid = 1'b0;
    logic        bready;

`ifdef CACHE_WRITEBACK_EN
    localparam int DIRTY_CYC = 21;
    localparam logic [7:0] EXP_AWLEN = 8'd7;
    localparam logic [3:0] EXP_WSTRB = 4'hF;
`else
    localparam int DIRTY_CYC = 11;
    localparam logic [7:0] EXP_AWLEN = 8'd0;
    localparam logic [3:0] EXP_WSTRB = 4'h0;
`endif

    cache_refill_ctrl dut (
        .clk(clk), .resetn(resetn), .miss(miss), .write_back(write_back),
        .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .refresh(refresh),
        .refill_we(refill_we), .refill_idx(refill_idx),
        .refill_wdata(refill_wdata), .evict_rdata(evict_rdata),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Data-array model: victim word i reads as DEAD_000i
    assign evict_rdata = 32'hDEAD_0000 | {29'd0, refill_idx};

    // Scoreboard queues
    logic [32:0] q_ar[$];  // {need_b_first, araddr}
    logic [31:0] q_aw[$];
    logic [35:0] q_w[$];   // {idx, wlast, wdata}
    logic [34:0] q_r[$];   // {idx, rdata}

    int   n_tests = 0;
    int   n_fail = 0;
    int   refresh_cnt = 0;
    int   refill_seen = 0;
    bit   bp = 1'b0;
    bit   aw_seen = 1'b0;
    bit   b_done = 1'b0;
    logic [31:0] r_base = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sample at negedge, pop and compare whatever the DUT presents
    logic        prev_ar, prev_aw, prev_w;
    logic [31:0] prev_araddr, prev_awaddr, prev_wdata;
    logic [2:0]  prev_widx;
    logic [32:0] e_ar;
    logic [31:0] e_aw;
    logic [35:0] e_w;
    logic [34:0] e_r;
    initial begin
        prev_ar = 0; prev_aw = 0; prev_w = 0;
        prev_araddr = 0; prev_awaddr = 0; prev_wdata = 0; prev_widx = 0;
    end
    always @(negedge clk) begin
        if (!resetn) begin
            prev_ar = 0; prev_aw = 0; prev_w = 0; b_done = 0;
        end else begin
            if (awvalid) aw_seen = 1'b1;
            if (refresh) refresh_cnt++;
            if (prev_ar) chk("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, prev_araddr}));
            if (prev_aw) chk("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, prev_awaddr}));
            if (prev_w)  chk("w_hold", 64'({wvalid, refill_idx, wdata}), 64'({1'b1, prev_widx, prev_wdata}));
            if (bvalid && bready) b_done = 1'b1;
            if (arvalid && arready) begin
                chk("ar_expected", 64'(q_ar.size() > 0), 64'd1);
                if (q_ar.size() > 0) begin
                    e_ar = q_ar.pop_front();
                    chk("araddr", 64'(araddr), 64'(e_ar[31:0]));
                    chk("ar_fields", 64'({arlen, arsize, arburst}), 64'({8'd7, 3'd2, 2'd1}));
                    chk("ar_after_b", 64'(b_done), 64'(e_ar[32]));
                end
                b_done = 1'b0;
            end
            if (awvalid && awready) begin
                chk("aw_expected", 64'(q_aw.size() > 0), 64'd1);
                if (q_aw.size() > 0) begin
                    e_aw = q_aw.pop_front();
                    chk("awaddr", 64'(awaddr), 64'(e_aw));
                    chk("aw_fields", 64'({awlen, awsize, awburst}), 64'({8'd7, 3'd2, 2'd1}));
                end
            end
            if (wvalid && wready) begin
                chk("w_expected", 64'(q_w.size() > 0), 64'd1);
                if (q_w.size() > 0) begin
                    e_w = q_w.pop_front();
                    chk("w_beat", 64'({refill_idx, wlast, wdata}), 64'(e_w));
                    chk("wstrb", 64'(wstrb), 64'hF);
                end
            end
            if (refill_we) begin
                refill_seen++;
                chk("r_expected", 64'(q_r.size() > 0), 64'd1);
                if (q_r.size() > 0) begin
                    e_r = q_r.pop_front();
                    chk("refill_beat", 64'({refill_idx, refill_wdata}), 64'(e_r));
                end
            end
            prev_ar = arvalid && !arready; prev_araddr = araddr;
            prev_aw = awvalid && !awready; prev_awaddr = awaddr;
            prev_w  = wvalid && !wready;   prev_wdata = wdata; prev_widx = refill_idx;
        end
    end

    // AXI slave model: readies/valids change 1 time unit after posedge
    bit s_ar, s_r, s_w, s_b, r_pend, b_pend;
    int r_beat;
    initial begin
        r_pend = 0; b_pend = 0; r_beat = 0;
        forever begin
            @(negedge clk);
            s_ar = arvalid && arready;
            s_r  = rvalid && rready;
            s_w  = wvalid && wready && wlast;
            s_b  = bvalid && bready;
            @(posedge clk);
            #1;
            if (!resetn) begin
                r_pend = 0; b_pend = 0; r_beat = 0;
            end else begin
                if (s_ar) begin r_pend = 1; r_beat = 0; end
                if (s_r) begin
                    r_beat++;
                    if (r_beat == 8) r_pend = 0;
                end
                if (s_w) b_pend = 1;
                if (s_b) b_pend = 0;
            end
            arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            rvalid  = r_pend && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            rdata   = r_base + 32'(r_beat);
            rlast   = (r_beat == 7);
            bvalid  = b_pend;
        end
    end

    // One miss: queue the expected traffic, pulse (or hold) miss, await refresh
    task automatic do_miss(input logic [31:0] raddr, input logic [31:0] waddr,
                           input bit wb, input logic [31:0] base, input bit hold,
                           input int exp_cyc);
        int  cyc;
        int  rc0;
        bit  got;
        bit  need_b;
        need_b = 1'b0;
`ifdef CACHE_WRITEBACK_EN
        if (wb) begin
            need_b = 1'b1;
            q_aw.push_back(waddr);
            for (int i = 0; i < 8; i++)
                q_w.push_back({3'(i), (i == 7), 32'hDEAD_0000 + 32'(i)});
        end
`endif
        q_ar.push_back({need_b, raddr});
        for (int i = 0; i < 8; i++) q_r.push_back({3'(i), base + 32'(i)});
        r_base = base;
        refill_seen = 0;
        rc0 = refresh_cnt;
        got = 1'b0;
        axi_raddr = raddr; axi_waddr = waddr; write_back = wb; miss = 1'b1;
        cyc = 1;
        for (int k = 0; k < 400 && !got; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hold) miss = 1'b0;
            if (refresh) begin
                got = 1'b1;
                miss = 1'b0;
                if (exp_cyc != 0) chk("refresh_cycle", 64'(cyc), 64'(exp_cyc));
            end
        end
        chk("refresh_seen", 64'(got), 64'd1);
        miss = 1'b0; write_back = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("refresh_once", 64'(refresh_cnt - rc0), 64'd1);
        chk("idle_after", 64'({arvalid, awvalid, rready, refresh}), 64'd0);
        chk("queues_drained", 64'(q_ar.size() + q_aw.size() + q_w.size() + q_r.size()), 64'd0);
    endtask

    int rc_mid;
    bit reached;
    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready, refresh, refill_we}), 64'd0);
        chk("rst_idx", 64'(refill_idx), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_ar_const", 64'({arlen, arsize, arburst}), 64'({8'd7, 3'd2, 2'd1}));
        chk("rst_aw_const", 64'({awlen, wstrb}), 64'({EXP_AWLEN, EXP_WSTRB}));
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Clean miss, zero backpressure: refresh lands at cycle 11
        do_miss(32'h0001_2340, 32'h0, 1'b0, 32'hA0, 1'b0, 11);
        // Dirty miss (direct AR when write-back is compiled out)
        do_miss(32'h0002_0000, 32'h0000_8E00, 1'b1, 32'h50, 1'b0, DIRTY_CYC);
        // miss held through the whole refill: one burst only
        do_miss(32'h0003_0100, 32'h0000_9000, 1'b1, 32'h60, 1'b1, DIRTY_CYC);
        do_miss(32'h0003_0180, 32'h0, 1'b0, 32'h70, 1'b1, 11);
        // Random backpressure on every channel
        bp = 1'b1;
        do_miss(32'h0005_5500, 32'h0, 1'b0, 32'h80, 1'b0, 0);
        do_miss(32'h0006_6600, 32'h0000_A0E0, 1'b1, 32'h90, 1'b0, 0);
        do_miss(32'h0007_7700, 32'h0000_B000, 1'b1, 32'h1000, 1'b1, 0);
        bp = 1'b0;

        // Reset asserted while refill beat 4 is on the bus
        q_ar.push_back({1'b0, 32'h0004_0000});
        for (int i = 0; i < 8; i++) q_r.push_back({3'(i), 32'hB0 + 32'(i)});
        r_base = 32'hB0;
        refill_seen = 0;
        rc_mid = refresh_cnt;
        axi_raddr = 32'h0004_0000; miss = 1'b1;
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            @(posedge clk);
            #1;
            miss = 1'b0;
            if (refill_seen >= 4) reached = 1'b1;
        end
        chk("mid_reached", 64'(reached), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_valids", 64'({arvalid, rready, refill_we, refresh}), 64'd0);
        chk("async_rst_idx", 64'(refill_idx), 64'd0);
        chk("async_rst_data", 64'({araddr, refill_wdata}), 64'd0);
        q_r.delete();
        q_ar.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("no_refresh_on_abort", 64'(refresh_cnt - rc_mid), 64'd0);
        do_miss(32'h0004_0040, 32'h0, 1'b0, 32'hC0, 1'b0, 11);

`ifndef CACHE_WRITEBACK_EN
        chk("aw_never", 64'(aw_seen), 64'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
